// File: rtl/spi_reg_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_reg_responder_pkg
// Description : Shared types and frame constants for the SPI register
//               responder (state encoding, command byte layout).
// Revision    : 1.0 - initial release
// ============================================================================
package spi_reg_responder_pkg;

  // Frame-level state of the responder
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_t;

  // Command byte length and position of the read/not-write flag inside it
  localparam int CMD_BITS = 8;
  localparam int RW_BIT   = 7;

  // Total number of SCK rises in a complete frame
  function automatic int frame_bits(input int data_w);
    return CMD_BITS + data_w;
  endfunction

endpackage : spi_reg_responder_pkg
`default_nettype wire

// File: rtl/spi_sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : spi_sync_edge
// Description : Multi-flop synchronizer for an asynchronous SPI pin with
//               single-cycle rise/fall pulses on the synchronized level.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic axi_aclk,
  input  logic axi_areset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  // Shift the raw pin through the synchronizer and remember the last level
  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      r_sync <= {SYNC_STAGES{RESET_VAL}};
      r_prev <= RESET_VAL;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], din};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign level = r_sync[SYNC_STAGES-1];
  assign rise  = level & ~r_prev;
  assign fall  = ~level & r_prev;

endmodule : spi_sync_edge
`default_nettype wire

// File: rtl/spi_reg_responder.sv
`default_nettype none
// ============================================================================
// Module      : spi_reg_responder
// Description : Mode-0 SPI slave giving an external master read/write access
//               to a local register bank. All SPI pins are oversampled in the
//               axi_aclk domain. Frame = 8-bit command + DATA_W data bits.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_reg_responder
  import spi_reg_responder_pkg::*;
#(
  parameter int NREGS       = 16,
  parameter int ADDR_W      = 4,
  parameter int DATA_W      = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic              axi_aclk,
  input  logic              axi_areset,
  input  logic              spi_sck_i,
  input  logic              spi_csn_i,
  input  logic              spi_mosi_i,
  output logic              spi_miso_o,
  output logic              spi_miso_t,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              reg_we,
  output logic              reg_re,
  input  logic [DATA_W-1:0] reg_rdata,
  output logic              frame_err,
  output logic              busy
);

  localparam int FRAME_BITS = frame_bits(DATA_W);
  localparam int CNT_W      = $clog2(FRAME_BITS + 1);

  // The register bank must fit in the command byte's address field
  if (NREGS > (1 << ADDR_W)) begin : g_nregs_check
    $error("NREGS does not fit in ADDR_W address bits");
  end

  logic w_sck_level, w_sck_rise, w_sck_fall;
  logic w_csn_level, w_csn_rise, w_csn_fall;
  logic w_mosi;

  // sck idles low in mode 0; csn idles high so reset never looks like a frame
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sck_sync (
    .axi_aclk  (axi_aclk),
    .axi_areset(axi_areset),
    .din       (spi_sck_i),
    .level     (w_sck_level),
    .rise      (w_sck_rise),
    .fall      (w_sck_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_csn_sync (
    .axi_aclk  (axi_aclk),
    .axi_areset(axi_areset),
    .din       (spi_csn_i),
    .level     (w_csn_level),
    .rise      (w_csn_rise),
    .fall      (w_csn_fall)
  );

  // MOSI needs only its level; same depth keeps it aligned with the sck pulses
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) r_mosi_sync <= '0;
    else            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi_i};
  end
  assign w_mosi = r_mosi_sync[SYNC_STAGES-1];

  state_t              r_state, w_state_next;
  logic [CNT_W-1:0]    r_bit_cnt;
  logic [CMD_BITS-2:0] r_cmd;
  logic                r_rd;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_tx;
  logic                r_miso, r_we, r_re, r_err;

  // State register
  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) r_state <= IDLE;
    else            r_state <= w_state_next;
  end

  // Next-state: csn edges take priority over any coincident sck edge
  always_comb begin
    w_state_next = r_state;
    if (w_csn_rise) begin
      w_state_next = IDLE;
    end else if (w_csn_fall) begin
      if (r_state == IDLE) w_state_next = CMD;
    end else if (w_sck_rise) begin
      if (r_state == CMD && r_bit_cnt == CNT_W'(CMD_BITS - 1))
        w_state_next = DATA;
      else if (r_state == DATA && r_bit_cnt == CNT_W'(FRAME_BITS - 1))
        w_state_next = DONE;
    end
  end

  // Frame datapath: shifting, strobes, MISO drive and abort detection
  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      r_bit_cnt <= '0;
      r_cmd     <= '0;
      r_rd      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_tx      <= '0;
      r_miso    <= 1'b0;
      r_we      <= 1'b0;
      r_re      <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_we  <= 1'b0;
      r_re  <= 1'b0;
      r_err <= 1'b0;
      if (w_csn_rise) begin
        // A frame that saw at least one rise but never reached DONE is short
        r_err  <= (r_state == DATA) || (r_state == CMD && r_bit_cnt != '0);
        r_miso <= 1'b0;
      end else if (w_csn_fall) begin
        if (r_state == IDLE) begin
          r_bit_cnt <= '0;
          r_cmd     <= '0;
          r_miso    <= 1'b0;
        end
      end else begin
        case (r_state)
          CMD: begin
            if (w_sck_rise) begin
              r_cmd     <= {r_cmd[CMD_BITS-3:0], w_mosi};
              r_bit_cnt <= r_bit_cnt + CNT_W'(1);
              if (r_bit_cnt == CNT_W'(CMD_BITS - 1)) begin
                r_addr <= {r_cmd[ADDR_W-2:0], w_mosi};
                r_rd   <= r_cmd[RW_BIT-1];
                r_re   <= r_cmd[RW_BIT-1];
              end
            end
          end
          DATA: begin
            // Read data is captured while reg_re is up and reg_addr is fresh
            if (r_re) begin
              r_tx <= reg_rdata;
            end else if (w_sck_fall && !w_sck_level && r_rd) begin
              r_miso <= r_tx[DATA_W-1];
              r_tx   <= {r_tx[DATA_W-2:0], 1'b0};
            end
            if (w_sck_rise) begin
              r_bit_cnt <= r_bit_cnt + CNT_W'(1);
              if (!r_rd) r_wdata <= {r_wdata[DATA_W-2:0], w_mosi};
              if (r_bit_cnt == CNT_W'(FRAME_BITS - 1)) begin
                r_we   <= ~r_rd;
                r_miso <= 1'b0;
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign spi_miso_o = r_miso;
  assign spi_miso_t = w_csn_level;
  assign busy       = ~w_csn_level;
  assign reg_addr   = r_addr;
  assign reg_wdata  = r_wdata;
  assign reg_we     = r_we;
  assign reg_re     = r_re;
  assign frame_err  = r_err;

endmodule : spi_reg_responder
`default_nettype wire

// File: tb/tb_spi_reg_responder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_spi_reg_responder
// Description : Scoreboard bench for spi_reg_responder. A bit-banged SPI
//               master issues directed and random frames at axi_aclk/8;
//               expected strobes are queued and popped by a monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_reg_responder;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 32;
  localparam int HP     = 4;   // SCK half period in axi_aclk cycles

  logic              axi_aclk   = 1'b0;
  logic              axi_areset = 1'b1;
  logic              spi_sck_i  = 1'b0;
  logic              spi_csn_i  = 1'b1;
  logic              spi_mosi_i = 1'b0;
  logic              spi_miso_o, spi_miso_t;
  logic [ADDR_W-1:0] reg_addr;
  logic [DATA_W-1:0] reg_wdata;
  logic              reg_we, reg_re, frame_err, busy;
  logic [DATA_W-1:0] reg_rdata;
  logic              bank_init = 1'b1;

  spi_reg_responder #(
    .NREGS(16), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SYNC_STAGES(2)
  ) dut (
    .axi_aclk  (axi_aclk),
    .axi_areset(axi_areset),
    .spi_sck_i (spi_sck_i),
    .spi_csn_i (spi_csn_i),
    .spi_mosi_i(spi_mosi_i),
    .spi_miso_o(spi_miso_o),
    .spi_miso_t(spi_miso_t),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_we    (reg_we),
    .reg_re    (reg_re),
    .reg_rdata (reg_rdata),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 axi_aclk = ~axi_aclk;

  // ---------------- environment: the register bank the DUT drives ----------
  function automatic logic [31:0] init_word(input int i);
    return 32'h5A00_0000 + 32'(i) * 32'h0101_0101;
  endfunction

  logic [31:0] env_bank [16];
  logic [31:0] model_bank [16];
  always @(posedge axi_aclk) begin
    if (bank_init) for (int i = 0; i < 16; i++) env_bank[i] <= init_word(i);
    else if (reg_we) env_bank[reg_addr] <= reg_wdata;
  end
  assign reg_rdata = env_bank[reg_addr];

  // ---------------- scoreboard ----------------------------------------------
  typedef struct packed { logic [3:0] addr; logic [31:0] data; } wr_t;
  wr_t        exp_wr[$];
  logic [3:0] exp_rd[$];
  bit         exp_err[$];
  wr_t        mon_w;
  logic [3:0] mon_a;
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every strobe the DUT presents must match the head of its queue
  always @(negedge axi_aclk) begin
    if (!axi_areset) begin
      if (reg_we) begin
        if (exp_wr.size() == 0) chk("unexpected_reg_we", 1, 0);
        else begin
          mon_w = exp_wr.pop_front();
          chk("we_addr", reg_addr, mon_w.addr);
          chk("we_data", reg_wdata, mon_w.data);
        end
      end
      if (reg_re) begin
        if (exp_rd.size() == 0) chk("unexpected_reg_re", 1, 0);
        else begin
          mon_a = exp_rd.pop_front();
          chk("re_addr", reg_addr, mon_a);
        end
      end
      if (frame_err) begin
        if (exp_err.size() == 0) chk("unexpected_frame_err", 1, 0);
        else void'(exp_err.pop_front());
      end
    end
  end

  // ---------------- SPI master ----------------------------------------------
  task automatic tick(input int n);
    repeat (n) begin @(posedge axi_aclk); #1; end
  endtask

  // Drive nbits SCK periods; MOSI moves one clock after each fall, MISO is
  // captured just before each rise. Bits past 40 are random filler.
  task automatic shift_bits(input logic [39:0] fr, input int nbits, output logic [39:0] cap);
    cap = '0;
    for (int i = 0; i < nbits; i++) begin
      tick(1);
      spi_mosi_i = (i < 40) ? fr[39-i] : 1'($urandom);
      tick(HP - 1);
      if (i < 40) cap[39-i] = spi_miso_o;
      spi_sck_i = 1'b1;
      tick(HP);
      spi_sck_i = 1'b0;
    end
  endtask

  task automatic frame(input logic [7:0] cmd, input logic [31:0] data, input int nbits);
    logic [39:0] cap;
    logic [3:0]  addr;
    bit          rd;
    addr = cmd[3:0];
    rd   = cmd[7];
    if (!rd && nbits >= 40) exp_wr.push_back(wr_t'({addr, data}));
    if (rd && nbits >= 8)   exp_rd.push_back(addr);
    if (nbits > 0 && nbits < 40) exp_err.push_back(1'b1);

    spi_csn_i = 1'b0;
    tick(HP);
    chk("busy_in_frame", busy, 1);
    chk("miso_t_in_frame", spi_miso_t, 0);
    shift_bits({cmd, data}, nbits, cap);
    tick(HP);
    spi_csn_i  = 1'b1;
    spi_mosi_i = 1'b0;
    tick(HP + 2);
    chk("busy_after_frame", busy, 0);
    chk("miso_t_after_frame", spi_miso_t, 1);

    if (nbits >= 40) begin
      chk("miso_cmd_byte_zero", cap[39:32], 0);
      if (rd) chk("miso_read_data", cap[31:0], model_bank[addr]);
      else begin
        chk("miso_write_zero", cap[31:0], 0);
        model_bank[addr] = data;
      end
    end
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_reg_we"},    reg_we,     0);
    chk({tag, "_reg_re"},    reg_re,     0);
    chk({tag, "_frame_err"}, frame_err,  0);
    chk({tag, "_busy"},      busy,       0);
    chk({tag, "_miso_t"},    spi_miso_t, 1);
    chk({tag, "_miso_o"},    spi_miso_o, 0);
    chk({tag, "_reg_addr"},  reg_addr,   0);
    chk({tag, "_reg_wdata"}, reg_wdata,  0);
  endtask

  // ---------------- stimulus ------------------------------------------------
  initial begin
    logic [39:0] junk;
    int lens [10] = '{0, 5, 8, 20, 39, 40, 40, 40, 41, 48};
    for (int i = 0; i < 16; i++) model_bank[i] = init_word(i);

    tick(4);
    check_reset_values("por");
    bank_init  = 1'b0;
    axi_areset = 1'b0;
    tick(4);
    check_reset_values("post_reset");

    // Basic write, then seed addr 5 and read it back
    frame(8'h03, 32'hCAFE_F00D, 40);
    frame(8'h05, 32'h7654_3210, 40);
    frame(8'h85, 32'h0, 40);

    // Abort after 20 bits, then a clean write to the same address
    frame(8'h02, 32'h1357_9BDF, 20);
    frame(8'h02, 32'h0000_00AA, 40);

    // Overrun with 8 extra bits, immediately followed by a read-back
    frame(8'h01, 32'h1234_5678, 48);
    frame(8'h81, 32'h0, 40);

    // Reset in the middle of the data phase of a write
    spi_csn_i = 1'b0;
    tick(HP);
    shift_bits({8'h06, 32'h1111_2222}, 20, junk);
    #2 axi_areset = 1'b1;
    #1 check_reset_values("mid_frame_reset");
    spi_csn_i  = 1'b1;
    spi_sck_i  = 1'b0;
    spi_mosi_i = 1'b0;
    tick(3);
    axi_areset = 1'b0;
    tick(HP);
    frame(8'h0F, 32'hDEAD_BEEF, 40);
    frame(8'h8F, 32'h0, 40);

    // csn pulse with no sck activity must be silent
    frame(8'h04, 32'h0, 0);

    // Random frames: random commands (reserved bits included) and lengths
    for (int n = 0; n < 24; n++)
      frame(8'($urandom), $urandom, lens[$urandom_range(9, 0)]);

    // Confirm every register through the read path
    for (int a = 0; a < 16; a++) frame(8'h80 | 8'(a), 32'h0, 40);

    tick(10);
    chk("pending_writes", exp_wr.size(), 0);
    chk("pending_reads", exp_rd.size(), 0);
    chk("pending_errors", exp_err.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog in case the stimulus ever stalls
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule : tb_spi_reg_responder
`default_nettype wire

// File: doc/spi_reg_responder.md
Name: spi_reg_responder

Overview:
- SPI slave (mode 0, MSB first) that lets an external SPI master (e.g. the PS SPI_1 controller, looped back through the board pins) read and write a local register bank.
- All SPI inputs are oversampled in the fabric clock domain, so there is no SCK clock domain.
- Sits beside the AXI register file in top and drives a register bank port of the same width/depth.

Parameters:
- NREGS, 16, number of 32-bit registers addressed.
- ADDR_W, 4, register address width (clog2 NREGS).
- DATA_W, 32, register data width.
- SYNC_STAGES, 2, flip-flop synchronizer depth on sck/csn/mosi.

Ports:
- axi_aclk  in  1  fabric clock; all logic on rising edge.
- axi_areset  in  1  asynchronous, active-high reset.
- spi_sck_i  in  1  SPI clock from master (IOBUF O).
- spi_csn_i  in  1  chip select, active low.
- spi_mosi_i  in  1  master-out data.
- spi_miso_o  out  1  slave-out data (IOBUF I).
- spi_miso_t  out  1  MISO tristate, 1 = high-Z (IOBUF T).
- reg_addr  out  ADDR_W  register address for current frame.
- reg_wdata  out  DATA_W  write data.
- reg_we  out  1  one-cycle write strobe.
- reg_re  out  1  one-cycle read strobe; reg_rdata is sampled the following cycle.
- reg_rdata  in  DATA_W  read data for reg_addr (combinational source).
- frame_err  out  1  one-cycle pulse on a short or aborted frame.
- busy  out  1  high while csn is low (synchronized).

Behaviour:
- Reset values: all outputs 0, except spi_miso_t = 1. State IDLE, shift registers 0.
- Synchronization and edge detection:
  - sck, csn and mosi each pass through SYNC_STAGES flops.
  - Edge detect on synchronized sck (rise/fall pulses) and on csn.
  - Supported SCK frequency is at most axi_aclk/8.
- Frame format: 40 bits.
  - Command byte: bit7 = R/nW (1 = read); bits6..ADDR_W reserved (ignored); bits ADDR_W-1..0 = address.
  - Then DATA_W data bits, MSB first.
- Mode 0: MOSI is sampled on the synchronized sck rise; MISO is updated on the synchronized sck fall.
- spi_miso_t = 0 exactly while synchronized csn is low; otherwise 1.
- State machine:
  - IDLE: wait for csn fall -> CMD, bit counter 0, busy = 1, miso_o = 0.
  - CMD: shift MOSI on each rise. On the 8th rise: latch reg_addr, latch the R/nW flag, pulse reg_re next cycle if read -> DATA.
  - DATA:
    - Read: reg_rdata is loaded into the tx shift register the cycle after reg_re. The first fall after the 8th rise drives bit DATA_W-1; each later fall drives the next bit.
    - Write: shift MOSI into reg_wdata.
    - On the 40th rise -> DONE.
    - Write frames pulse reg_we the cycle after the 40th rise, with reg_addr/reg_wdata stable from that cycle until the next frame's 8th rise.
  - DONE: further sck edges are ignored and miso_o = 0. csn rise -> IDLE.
- miso_o = 0 during the command byte and on write frames.
- Boundary conditions:
  - csn rises in CMD or DATA (fewer than 40 rises): frame_err pulses once; no reg_we; -> IDLE.
  - csn rises with 0 rises: no error; -> IDLE.
  - More than 40 rises: the extra bits are ignored; no second reg_we.
  - csn falls in the same cycle as an sck edge: csn takes priority and the sck edge is ignored.
  - axi_areset mid-frame: immediate return to reset values; no strobe. The next frame starts only on a fresh csn fall observed after reset release.
  - Back-to-back frames (csn high for at least 2 synchronized cycles) are handled independently.
  - The bit counter saturates at 40.

Decomposition:
- Package spi_reg_responder_pkg holds:
  - state enum (IDLE, CMD, DATA, DONE);
  - CMD_BITS = 8;
  - RW_BIT = 7;
  - FRAME_BITS = CMD_BITS + DATA_W (helper function).
- Sub-module spi_sync_edge: parameterised SYNC_STAGES synchronizer that outputs the level plus rise/fall pulses. Instantiated for sck and csn; the level-only output is used for mosi.

Test Plan:
- Write frame: cmd 0x03, data 0xCAFE_F00D -> exactly one reg_we with reg_addr = 3, reg_wdata = 0xCAFEF00D; frame_err = 0.
- Read frame: cmd 0x85 with reg_rdata = 0x7654_3210 when addr = 5 -> reg_re pulses once, addr = 5; master captures 0x76543210 on MISO; miso_t = 0 only while csn low.
- Abort: csn rises after 20 sck cycles of a write to addr 2 -> frame_err single pulse, no reg_we, next frame (write 0x02, 0x0000_00AA) succeeds.
- Overrun plus back-to-back: 48 sck cycles, write cmd 0x01 data 0x1234_5678 then 8 extra bits -> one reg_we with 0x12345678; immediate read cmd 0x81 returns the bank value.
- Reset mid-frame: assert axi_areset during DATA of a write -> outputs at reset values, no reg_we; a subsequent full write of 0xDEADBEEF to addr 0xF completes correctly.
- SCK at axi_aclk/8 with sck/mosi skewed by 1 clock -> all of the above still pass.
